// File: rtl/apb_master_arbiter_pkg.sv
// Shared APB definitions: bus widths, arbiter defaults, FSM states and latched payload.
package apb_master_arbiter_pkg;

  localparam int unsigned APB_ADDR_WIDTH  = 32;
  localparam int unsigned APB_DATA_WIDTH  = 32;
  localparam int unsigned STRB_W          = APB_DATA_WIDTH / 8;

  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]         strb;
    logic [2:0]                prot;
  } apb_payload_t;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr wins (one-hot).
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);

  logic [PTR_W-1:0] w_pos;

  // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
  always_comb begin
    winner = '0;
    w_pos  = '0;
    for (int unsigned i = N; i > 0; i--) begin
      w_pos = PTR_W'((32'(ptr) + i - 1) % N);
      if (req[w_pos]) begin
        winner        = '0;
        winner[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with an ACCESS-phase timeout that completes the transfer with an error.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]         req_strb,
  input  logic [NUM_REQ*3-1:0]              req_prot,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                done,
  output logic [APB_DATA_WIDTH-1:0]         rsp_rdata,
  output logic                              rsp_error,
  output logic                              psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [APB_ADDR_WIDTH-1:0]         paddr,
  output logic [APB_DATA_WIDTH-1:0]         pwdata,
  output logic [STRB_W-1:0]                 pstrb,
  output logic [2:0]                        pprot,
  input  logic                              pready,
  input  logic                              pslverr,
  input  logic [APB_DATA_WIDTH-1:0]         prdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  apb_state_t                r_state;
  logic [IDX_W-1:0]          r_ptr;     // index where the next search starts
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  apb_payload_t              r_pay;
  logic                      r_psel;
  logic                      r_penable;
  logic [NUM_REQ-1:0]        r_gnt;
  logic [NUM_REQ-1:0]        r_done;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_error;

  logic [NUM_REQ-1:0]        w_winner;
  logic [IDX_W-1:0]          w_idx;
  apb_payload_t              w_lane [NUM_REQ];
  apb_payload_t              w_sel;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(IDX_W)) u_rr (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner)
  );

  // One-hot winner to binary index.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_idx = IDX_W'(i);
    end
  end

  // Unpack the per-requester payload lanes and pick the winner's.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_lane[i].write = req_write[i];
      w_lane[i].addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      w_lane[i].wdata = req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      w_lane[i].strb  = req_strb[i*STRB_W +: STRB_W];
      w_lane[i].prot  = req_prot[i*3 +: 3];
    end
    w_sel = w_lane[w_idx];
  end

  // Arbitration / APB sequencing FSM; all outputs registered, pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pay       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state <= SETUP;
            r_idx   <= w_idx;
            r_pay   <= w_sel;
            r_psel  <= 1'b1;
            r_gnt   <= w_winner;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_ptr     <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
        ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle.
          if (pready || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pay     <= '0;
            r_cnt     <= '0;
            r_done    <= NUM_REQ'(1) << r_idx;
            if (pready) begin
              r_rsp_error <= pslverr;
              r_rsp_rdata <= r_pay.write ? '0 : prdata;
            end else begin
              r_rsp_error <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pay.write;
  assign paddr     = r_pay.addr;
  assign pwdata    = r_pay.wdata;
  assign pstrb     = r_pay.strb;
  assign pprot     = r_pay.prot;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: vector table of single transfers plus reset/contention sequences.
module tb_apb_master_arbiter;
  import apb_master_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned AW = APB_ADDR_WIDTH;
  localparam int unsigned DW = APB_DATA_WIDTH;
  localparam int unsigned SW = STRB_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*SW-1:0] req_strb;
  logic [NR*3-1:0]  req_prot;
  logic [NR-1:0]    gnt, done;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_error, psel, penable, pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [SW-1:0]    pstrb;
  logic [2:0]       pprot;
  logic             pready, pslverr;
  logic [DW-1:0]    prdata;

  apb_master_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;     // ACCESS cycles before pready; >= TO means never
    bit          slverr;
    logic [31:0] prdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;   // ACCESS cycles the transfer should last
  } vec_t;

  typedef struct {
    int          id;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  vec_t vecs [7];
  rsp_t sb [$];
  int   passed = 0;
  int   total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // One transfer from an idle arbiter: grant, payload, ACCESS stability, completion.
  task automatic run_vec(input vec_t v);
    rsp_t r;
    int   k;
    bit   got;
    req = '0;
    req[v.id] = 1'b1;
    req_write[v.id] = v.wr;
    req_addr[v.id*AW +: AW]  = v.addr;
    req_wdata[v.id*DW +: DW] = v.wdata;
    req_strb[v.id*SW +: SW]  = v.strb;
    req_prot[v.id*3 +: 3]    = v.prot;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    tick();
    check("setup_gnt", gnt, 32'(1 << v.id));
    check("setup_done", done, 0);
    check("setup_ctl", {psel, penable, pwrite}, {2'b10, v.wr});
    check("setup_paddr", paddr, v.addr);
    check("setup_pwdata", pwdata, v.wdata);
    check("setup_pstrb_pprot", {pstrb, pprot}, {v.strb, v.prot});
    sb.push_back('{v.id, v.exp_err, v.exp_rdata});
    req = '0;
    tick();
    got = 1'b0;
    for (k = 0; k < 40 && !got; k++) begin
      check("access_ctl", {psel, penable}, 2'b11);
      check("access_paddr", paddr, v.addr);
      check("access_pwdata", pwdata, v.wdata);
      pready  = (k == v.waits);
      pslverr = v.slverr;
      prdata  = v.prdata;
      tick();
      pready  = 1'b0;
      if (done != 0) got = 1'b1;
    end
    if (!got) begin
      check("done_timeout", 0, 1);
    end else begin
      check("access_cycles", k, v.exp_acc);
      if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        r = sb.pop_front();
        check("done_onehot", done, 32'(1 << r.id));
        check("rsp_error", rsp_error, r.err);
        check("rsp_rdata", rsp_rdata, r.rdata);
      end
      check("done_gnt", gnt, 0);
      check("idle_ctl", {psel, penable, pwrite}, 0);
      check("idle_paddr", paddr, 0);
      check("idle_pwdata", pwdata, 0);
      check("idle_pstrb_pprot", {pstrb, pprot}, 0);
    end
  endtask

  initial begin
    int exp_order [5];
    int ngnt;
    bit pending;
    rst = 1'b1; req = '0; req_write = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    for (int i = 0; i < int'(NR); i++) begin
      req_addr[i*AW +: AW]  = $urandom();
      req_wdata[i*DW +: DW] = $urandom();
      req_strb[i*SW +: SW]  = SW'($urandom());
      req_prot[i*3 +: 3]    = 3'($urandom());
    end
    exp_order = '{0, 1, 2, 3, 0};

    //          id wr addr          wdata         strb  prot waits slverr prdata       err rdata        acc
    vecs[0] = '{1, 1, 32'h10,       32'hA5A5A5A5, 4'hF, 3'd0, 0,   0, 32'h0,        0, 32'h0,        1};
    vecs[1] = '{2, 0, 32'h20,       32'h0,        4'h0, 3'd2, 3,   0, 32'h12345678, 0, 32'h12345678, 4};
    vecs[2] = '{0, 1, 32'h30,       32'h0BADF00D, 4'hF, 3'd1, 0,   1, 32'h0,        1, 32'h0,        1};
    vecs[3] = '{3, 0, 32'h40,       32'h0,        4'h0, 3'd0, 15,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 16};
    vecs[4] = '{1, 0, 32'h50,       32'h0,        4'h0, 3'd7, 255, 0, 32'h55AA55AA, 1, 32'h0,        16};
    vecs[5] = '{2, 1, 32'h60,       32'h13572468, 4'h3, 3'd5, 1,   0, 32'hFFFFFFFF, 0, 32'h0,        2};
    vecs[6] = '{0, 0, 32'hFFFFFFFC, 32'h0,        4'h0, 3'd4, 2,   1, 32'h0000CAFE, 1, 32'h0000CAFE, 3};

    tick(); tick();
    check("rst_gnt_done", {gnt, done}, 0);
    check("rst_ctl", {psel, penable, pwrite, rsp_error}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of ACCESS must abort silently and restart the pointer.
    req = 4'b0100; req_write[2] = 1'b0; pready = 1'b0;
    tick();
    check("pre_rst_gnt", gnt, 4'b0100);
    req = '0;
    tick(); tick();
    check("pre_rst_access", {psel, penable}, 2'b11);
    rst = 1'b1;
    tick();
    check("post_rst_ctl", {psel, penable}, 0);
    check("post_rst_pulses", {gnt, done}, 0);
    rst = 1'b0; req = '1; pready = 1'b1; pslverr = 1'b0;

    // Contention: round-robin order with each done ahead of the next grant.
    ngnt = 0; pending = 1'b0; sb.delete();
    for (int c = 0; c < 60 && !(ngnt == 5 && !pending); c++) begin
      tick();
      if ((gnt | done) != 0) check("gnt_done_excl", gnt & done, 0);
      if (gnt != 0) begin
        check("gnt_after_done", pending, 0);
        if (ngnt < 5) begin
          check("rr_order", gnt, 32'(1 << exp_order[ngnt]));
          sb.push_back('{exp_order[ngnt], 1'b0, 32'h0});
        end else begin
          check("extra_gnt", 0, 1);
        end
        pending = 1'b1;
        ngnt++;
        if (ngnt == 5) req = '0;
      end
      if (done != 0) begin
        check("done_after_gnt", pending, 1);
        if (sb.size() != 0) check("rr_done", done, 32'(1 << sb.pop_front().id));
        else check("rr_done_sb", 0, 1);
        pending = 1'b0;
      end
    end
    check("contention_grants", ngnt, 5);
    check("contention_drained", pending, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
